// File: rtl/ntt_job_sequencer_pkg.sv
// Shared definitions for the NTT job sequencer: FSM state encoding, job counter width
// and the bit-reversal helper used by the optional NTT_SEQ_BITREV_OUT_EN read order.
package ntt_job_sequencer_pkg;

  typedef logic [1:0] seq_state_t;

  // state    | meaning
  // LOAD     | accept input beats and write them into the core
  // START    | single-cycle start pulse to the core
  // COMPUTE  | wait for the core's completion pulse
  // DRAIN    | read results out of the core into the output stream
  localparam seq_state_t ST_LOAD    = 2'd0;
  localparam seq_state_t ST_START   = 2'd1;
  localparam seq_state_t ST_COMPUTE = 2'd2;
  localparam seq_state_t ST_DRAIN   = 2'd3;

  localparam int JOB_CNT_W = 16;

  // Reverses the low 'width' bits of value; bits above 'width' come back as zero.
  function automatic logic [15:0] bit_reverse(input logic [15:0] value, input int width);
    logic [15:0] src;
    logic [15:0] res;
    src = value;
    res = '0;
    for (int i = 0; i < 16; i++) begin
      if (i < width) begin
        res = {res[14:0], src[0]};
        src = {1'b0, src[15:1]};
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/ntt_job_sequencer_out.sv
// Two-entry output FIFO (ntt_out_skid_fifo) holding core read data on its way to the
// result stream; the head entry stays put until it is popped.
module ntt_out_skid_fifo #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             push_last,
  input  logic             pop,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic [1:0]       count
);

  logic [WIDTH:0] entry0;
  logic [WIDTH:0] entry1;
  logic           wr_ptr;
  logic           rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry0 <= '0;
      entry1 <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        if (wr_ptr) entry1 <= {push_last, push_data};
        else        entry0 <= {push_last, push_data};
        wr_ptr <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign out_valid = (count != 2'd0);
  assign {out_last, out_data} = rd_ptr ? entry1 : entry0;

endmodule

// File: rtl/ntt_job_sequencer.sv
// NTT job sequencer: loads N coefficients into the core, starts it, waits for done and
// streams the results out. Define NTT_SEQ_BITREV_OUT_EN to read results in bit-reversed order.
module ntt_job_sequencer
  import ntt_job_sequencer_pkg::*;
#(
  parameter int N          = 256,
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_last,
  output logic                  core_start,
  input  logic                  core_done,
  input  logic                  core_busy,
  output logic                  core_load_coeff,
  output logic [ADDR_WIDTH-1:0] core_load_addr,
  output logic [WIDTH-1:0]      core_load_data,
  output logic [ADDR_WIDTH-1:0] core_read_addr,
  input  logic [WIDTH-1:0]      core_read_data,
  output logic                  seq_busy,
  output logic [JOB_CNT_W-1:0]  job_count
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(N - 1);
  localparam logic [ADDR_WIDTH:0]   RD_END   = (ADDR_WIDTH + 1)'(N);

  seq_state_t            state;
  logic [ADDR_WIDTH-1:0] load_cnt;
  logic [ADDR_WIDTH:0]   rd_cnt;
  logic                  rd_pending;
  logic                  rd_pending_last;
  logic [1:0]            fifo_count;
  logic                  load_fire;
  logic                  rd_issue;
  logic                  pop;
  logic                  core_busy_unused;

  // Completion is signalled by core_done alone; the busy flag carries no control meaning here.
  assign core_busy_unused = core_busy;

  assign load_fire       = (state == ST_LOAD) && in_valid;
  assign in_ready        = (state == ST_LOAD);
  assign core_load_coeff = load_fire;
  assign core_load_addr  = load_cnt;
  assign core_load_data  = load_fire ? in_data : '0;
  assign core_start      = (state == ST_START);
  assign seq_busy        = !((state == ST_LOAD) && (load_cnt == '0));
  assign pop             = out_valid && out_ready;

  // Occupancy is taken net of this cycle's pop so a continuously ready sink gets one beat per cycle.
  assign rd_issue = (state == ST_DRAIN) && (rd_cnt != RD_END) &&
                    (({1'b0, fifo_count} + {2'b00, rd_pending} - {2'b00, pop}) < 3'd2);

`ifdef NTT_SEQ_BITREV_OUT_EN
  assign core_read_addr = ADDR_WIDTH'(bit_reverse(16'(rd_cnt[ADDR_WIDTH-1:0]), ADDR_WIDTH));
`else
  assign core_read_addr = rd_cnt[ADDR_WIDTH-1:0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_LOAD;
      load_cnt        <= '0;
      rd_cnt          <= '0;
      rd_pending      <= 1'b0;
      rd_pending_last <= 1'b0;
      job_count       <= '0;
    end else begin
      rd_pending      <= rd_issue;
      rd_pending_last <= rd_issue && (rd_cnt == {1'b0, LAST_IDX});
      case (state)
        ST_LOAD: begin
          if (load_fire) begin
            if (load_cnt == LAST_IDX) begin
              load_cnt <= '0;
              state    <= ST_START;
            end else begin
              load_cnt <= load_cnt + 1'b1;
            end
          end
        end
        ST_START: state <= ST_COMPUTE;
        ST_COMPUTE: begin
          if (core_done) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (rd_issue) rd_cnt <= rd_cnt + 1'b1;
          if (pop && out_last) begin
            state     <= ST_LOAD;
            rd_cnt    <= '0;
            job_count <= job_count + 1'b1;
          end
        end
        default: state <= ST_LOAD;
      endcase
    end
  end

  ntt_out_skid_fifo #(
    .WIDTH(WIDTH)
  ) u_out_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (rd_pending),
    .push_data (core_read_data),
    .push_last (rd_pending_last),
    .pop       (pop),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_ntt_job_sequencer.sv
// Self-checking bench for ntt_job_sequencer with a behavioural core stub and a job-level model.
module tb_ntt_job_sequencer;

`ifdef NTT_SEQ_BITREV_OUT_EN
  localparam int N        = 8;
  localparam int AW       = 3;
  localparam int RST_BEAT = 4;
`else
  localparam int N        = 256;
  localparam int AW       = 8;
  localparam int RST_BEAT = 100;
`endif
  localparam int W = 32;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          out_last;
  logic          core_start;
  logic          core_done;
  logic          core_busy;
  logic          core_load_coeff;
  logic [AW-1:0] core_load_addr;
  logic [W-1:0]  core_load_data;
  logic [AW-1:0] core_read_addr;
  logic [W-1:0]  core_read_data;
  logic          seq_busy;
  logic [15:0]   job_count;

  ntt_job_sequencer #(.N(N), .WIDTH(W), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .core_start(core_start), .core_done(core_done), .core_busy(core_busy),
    .core_load_coeff(core_load_coeff), .core_load_addr(core_load_addr),
    .core_load_data(core_load_data),
    .core_read_addr(core_read_addr), .core_read_data(core_read_data),
    .seq_busy(seq_busy), .job_count(job_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // "Core" result for a stored coefficient: a fixed, easily hand-computed transform.
  function automatic logic [W-1:0] xf(input logic [W-1:0] x);
    return (x << 4) ^ 32'hA5A5_0000;
  endfunction

  // Address the k-th output beat is expected to come from.
  function automatic int raddr(input int k);
`ifdef NTT_SEQ_BITREV_OUT_EN
    int r;
    r = 0;
    for (int b = 0; b < AW; b++) r = r * 2 + ((k >> b) & 1);
    return r;
`else
    return k;
`endif
  endfunction

  // Core stub: coefficient memory, registered read port, done pulse 10 cycles after start.
  logic [W-1:0] core_mem [N];
  int unsigned  dcnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dcnt           <= 0;
      core_done      <= 1'b0;
      core_busy      <= 1'b0;
      core_read_data <= '0;
    end else begin
      if (core_load_coeff) core_mem[core_load_addr] <= core_load_data;
      core_read_data <= xf(core_mem[core_read_addr]);
      core_done      <= !core_start && (dcnt == 1);
      core_busy      <= core_start || (dcnt > 3);
      if (core_start)     dcnt <= 9;
      else if (dcnt != 0) dcnt <= dcnt - 1;
    end
  end

  // Job-level model: 0 loading, 1 start cycle, 2 computing, 3 draining.
  int           phase = 0;
  int           loads = 0;
  int           beats = 0;
  int           jobs_exp = 0;
  int           jobs_total = 0;
  int           starts = 0;
  logic [W-1:0] job_in [N];
  logic [W-1:0] cap [N];
  logic         stall = 1'b0;
  logic [W-1:0] stall_data;
  logic         stall_last;

  always @(negedge clk) begin
    if (!rst_n) begin
      phase    = 0;
      loads    = 0;
      beats    = 0;
      jobs_exp = 0;
      starts   = 0;
      stall    = 1'b0;
    end else begin
      chk("in_ready", 32'(in_ready), 32'(phase == 0));
      chk("core_start", 32'(core_start), 32'(phase == 1));
      chk("seq_busy", 32'(seq_busy), 32'(!(phase == 0 && loads == 0)));
      chk("job_count", 32'(job_count), 32'(jobs_exp));
      if (phase != 0) chk("load_coeff_idle", 32'(core_load_coeff), 32'd0);
      if (phase != 3) chk("out_valid_idle", 32'(out_valid), 32'd0);
      if (stall) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_data", out_data, stall_data);
        chk("stall_last", 32'(out_last), 32'(stall_last));
      end
      stall      = out_valid && !out_ready;
      stall_data = out_data;
      stall_last = out_last;
      case (phase)
        0: begin
          if (in_valid) begin
            chk("load_coeff", 32'(core_load_coeff), 32'd1);
            chk("load_addr", 32'(core_load_addr), 32'(loads));
            chk("load_data", core_load_data, in_data);
            job_in[loads] = in_data;
            loads++;
            if (loads == N) begin
              loads = 0;
              phase = 1;
            end
          end else begin
            chk("load_coeff_novalid", 32'(core_load_coeff), 32'd0);
          end
        end
        1: begin
          starts++;
          phase = 2;
        end
        2: if (core_done) phase = 3;
        default: begin
          if (out_valid && out_ready) begin
            chk("out_data", out_data, xf(job_in[raddr(beats)]));
            chk("out_last", 32'(out_last), 32'(beats == N - 1));
            cap[beats] = out_data;
            beats++;
            if (beats == N) begin
              chk("start_pulses", 32'(starts), 32'd1);
              starts     = 0;
              beats      = 0;
              jobs_exp   = (jobs_exp + 1) & 16'hFFFF;
              jobs_total++;
              phase      = 0;
            end
          end
        end
      endcase
    end
  end

  // Sink readiness pattern: 0 always ready, 1 alternating 1,0, 2 two-of-three ready.
  int mode = 0;
  int cyc  = 0;
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = cyc[0];
        default: out_ready = (cyc % 3) != 0;
      endcase
    end
  end

  task automatic run_load(input logic [W-1:0] base, input logic [W-1:0] step, input bit hold);
    for (int i = 0; i < N; i++) begin
      bit hs;
      int guard;
      hs       = 1'b0;
      guard    = 0;
      in_valid = 1'b1;
      in_data  = base + step * 32'(i);
      while (!hs && guard < 2000) begin
        @(negedge clk);
        hs = in_ready;
        @(posedge clk);
        #1;
        guard++;
      end
      chk("load_handshake", 32'(hs), 32'd1);
    end
    in_valid = hold;
    in_data  = 32'hDEAD_BEEF;
  endtask

  task automatic wait_job_end();
    int start_jobs;
    int guard;
    start_jobs = jobs_total;
    guard      = 0;
    while (jobs_total == start_jobs && guard < 5000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    chk("job_end_seen", 32'(jobs_total - start_jobs), 32'd1);
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_core_start", 32'(core_start), 32'd0);
    chk("rst_load_coeff", 32'(core_load_coeff), 32'd0);
    chk("rst_seq_busy", 32'(seq_busy), 32'd0);
    chk("rst_job_count", 32'(job_count), 32'd0);
    chk("rst_read_addr", 32'(core_read_addr), 32'd0);
    #21;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("in_ready_after_reset", 32'(in_ready), 32'd1);

    // Job A: ramp, in_valid held high past the load, sink always ready.
    mode = 0;
    run_load(32'd0, 32'd1, 1'b1);
    wait_job_end();
    chk("pin_a_beat0", cap[0], 32'hA5A5_0000);
`ifdef NTT_SEQ_BITREV_OUT_EN
    chk("pin_a_beat1", cap[1], 32'hA5A5_0040);
    chk("pin_a_last", cap[N-1], 32'hA5A5_0070);
`else
    chk("pin_a_beat1", cap[1], 32'hA5A5_0010);
    chk("pin_a_last", cap[N-1], 32'hA5A5_0FF0);
`endif
    chk("pin_a_jobs", 32'(job_count), 32'd1);

    // Job B back-to-back with alternating sink readiness.
    mode = 1;
    run_load(32'h1000, 32'd7, 1'b0);
    wait_job_end();
    chk("pin_b_beat0", cap[0], 32'hA5A4_0000);
    chk("pin_b_jobs", 32'(job_count), 32'd2);

    // Job C aborted by reset mid-drain while a beat is being offered.
    mode = 2;
    run_load(32'h2000, 32'd3, 1'b0);
    begin
      int guard;
      guard = 0;
      while (!(beats >= RST_BEAT && out_valid) && guard < 5000) begin
        @(posedge clk);
        #1;
        guard++;
      end
      chk("drain_reached", 32'(out_valid), 32'd1);
    end
    #3;
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_job_count", 32'(job_count), 32'd0);
    chk("abort_seq_busy", 32'(seq_busy), 32'd0);
    chk("abort_core_start", 32'(core_start), 32'd0);
    @(negedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Job D after the abort must load from address 0 and complete normally.
    mode = 0;
    run_load(32'h3000, 32'd5, 1'b0);
    wait_job_end();
    chk("pin_d_jobs", 32'(job_count), 32'd1);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ntt_job_sequencer.md
NTT_JOB_SEQUENCER -- requirements
Module: ntt_job_sequencer

Interface
REQ-001 Parameters, one per line: N, 256, NTT size; WIDTH, 32, coefficient width; ADDR_WIDTH, 8, log2(N).
REQ-002 clk  in  1  single clock; all logic on posedge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 in_valid / in_ready / in_data  in/out/in  1/1/WIDTH  input coefficient stream, natural order.
REQ-005 out_valid / out_ready / out_data / out_last  out/in/out/out  1/1/WIDTH/1  result stream; out_last marks beat N-1.
REQ-006 core_start  out  1  one-cycle start pulse to the NTT core.
REQ-007 core_done / core_busy  in  1/1  completion pulse and busy flag from the core.
REQ-008 core_load_coeff / core_load_addr / core_load_data  out  1/ADDR_WIDTH/WIDTH  coefficient write port of the core.
REQ-009 core_read_addr / core_read_data  out/in  ADDR_WIDTH/WIDTH  core read port; data is registered, one-cycle latency.
REQ-010 seq_busy / job_count  out  1/16  job in progress; completed-job counter.

Function
REQ-011 The FSM SHALL have four states: LOAD, START, COMPUTE and DRAIN.
REQ-012 LOAD: in_ready=1; each handshake SHALL drive, combinationally in the same cycle, core_load_coeff=1, core_load_addr=load_cnt and core_load_data=in_data, then increment load_cnt.
REQ-013 The handshake with load_cnt=N-1 SHALL move the FSM to START and clear load_cnt.
REQ-014 START: core_start=1 for exactly one cycle, then unconditionally move to COMPUTE.
REQ-015 COMPUTE: wait for core_done=1, then move to DRAIN; core_done SHALL be ignored in every other state.
REQ-016 Outside LOAD, in_ready=0 and core_load_coeff=0.
REQ-017 DRAIN: reads SHALL be issued on core_read_addr with rd_cnt running 0..N-1; the returned data SHALL go to a 2-entry output FIFO.
REQ-018 A read SHALL be issued only when FIFO occupancy plus in-flight reads is less than 2; full throughput is one beat per cycle while out_ready=1.
REQ-019 out_valid SHALL equal FIFO non-empty; out_data and out_last SHALL hold stable while out_valid=1 and out_ready=0.
REQ-020 The handshake carrying out_last SHALL increment job_count (wraps at 2^16) and return the FSM to LOAD; in_ready SHALL be 1 in the next cycle.
REQ-021 seq_busy SHALL be 0 only in LOAD with load_cnt=0.
REQ-022 A core_busy=0 sample in COMPUTE SHALL NOT cause a transition; only core_done moves the FSM out of COMPUTE.

Reset
REQ-023 rst_n low SHALL immediately force: state LOAD; load_cnt, rd_cnt, in-flight count and FIFO occupancy to 0; job_count 0; all outputs 0 except in_ready, which SHALL be 1 after release.
REQ-024 Reset mid-job SHALL discard the job; the next accepted beat SHALL be written to address 0.

Configuration
REQ-025 Macro NTT_SEQ_BITREV_OUT_EN defined: core_read_addr SHALL be bit_reverse(rd_cnt) over ADDR_WIDTH bits.
REQ-026 Macro NTT_SEQ_BITREV_OUT_EN undefined: core_read_addr SHALL be rd_cnt; this is the default.

Structure
REQ-027 A shared package SHALL hold the state enum, the job_count width constant (16) and the bit_reverse function.
REQ-028 The 2-entry output FIFO SHALL be a sub-module named ntt_out_skid_fifo; all other logic SHALL be inline.

Verification
REQ-029 N=256, ramp 0..255 in, core stub raises core_done 10 cycles after core_start -> core_start exactly once, in the cycle after the 256th handshake; 256 out beats with out_last only on the last; job_count=1.
REQ-030 Ramp job, out_ready pattern 1,0,1,0 -> output sequence equals addresses 0..255, no drop, no duplicate; out_data stable during stalls.
REQ-031 N=8, ADDR_WIDTH=3, NTT_SEQ_BITREV_OUT_EN defined -> read address order 0,4,2,6,1,5,3,7.
REQ-032 in_valid held high through START, COMPUTE and DRAIN -> in_ready=0 and core_load_coeff=0 throughout.
REQ-033 rst_n pulsed low at DRAIN beat 100 -> out_valid drops with no clock edge; the next job loads from address 0; job_count=0.
REQ-034 Two back-to-back jobs -> in_ready=1 in the cycle after the out_last handshake; job_count=2; second output stream correct.
